// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared constants and types for the pipelined carry-select subtractor.
//   CSA_WIDTH       default operand width
//   CSA_SLICE       default low/high split point (CSA_WIDTH = 2*CSA_SLICE)
//   stage1Payload_t data carried from stage 1 to stage 2
// Optional feature macro used by the users of this package: CSA_SUB_OVF_EN
// ---------------------------------------------------------------------------
package csa_pkg;

    localparam int CSA_WIDTH = 8;
    localparam int CSA_SLICE = 4;

    // Everything stage 2 needs to finish the subtraction: the finished low
    // slice, both speculative high slices, and the operand sign bits used by
    // the optional signed-overflow flag.  The field widths follow CSA_SLICE,
    // so a build with a different SLICE must change these constants as well.
    typedef struct packed {
        logic [CSA_SLICE-1:0] lowDiff;
        logic                 lowBorrow;
        logic [CSA_SLICE-1:0] highDiff0;
        logic [CSA_SLICE-1:0] highDiff1;
        logic                 highBorrow0;
        logic                 highBorrow1;
        logic                 aSign;
        logic                 bSign;
    } stage1Payload_t;

endpackage

// File: rtl/csa_sub_8bit_if.sv
// ---------------------------------------------------------------------------
// csa_sub_8bit_if
// Operand/result bus of csa_sub_8bit with valid/ready handshakes on both
// sides.
//   in_valid/in_ready   operand handshake (a, b, bin)
//   out_valid/out_ready result handshake (diff, bout, ovf)
//   ovf                 present only when CSA_SUB_OVF_EN is defined
// master = the side driving operands and consuming results (testbench or
// upstream logic); slave = the subtractor.
// ---------------------------------------------------------------------------
interface csa_sub_8bit_if #(
    parameter int WIDTH = csa_pkg::CSA_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef CSA_SUB_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
`endif

endinterface

// File: rtl/csa_sub_slice.sv
// ---------------------------------------------------------------------------
// csa_sub_slice
// SLICE-bit ripple-borrow subtractor: diff_o = x_i - y_i - bin_i.
//   x_i    minuend slice
//   y_i    subtrahend slice
//   bin_i  borrow in
//   diff_o difference slice (mod 2^SLICE)
//   bout_o borrow out, 1 when x_i < y_i + bin_i
// ---------------------------------------------------------------------------
module csa_sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x_i,
    input  logic [SLICE-1:0] y_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] diff_o,
    output logic             bout_o
);

    logic [SLICE:0] borrow;

    // Classic full-subtractor chain: a bit borrows when y exceeds x, or when
    // they are equal and the lower bit already borrowed.
    always_comb begin
        borrow    = '0;
        diff_o    = '0;
        borrow[0] = bin_i;
        for (int i = 0; i < SLICE; i++) begin
            diff_o[i]     = x_i[i] ^ y_i[i] ^ borrow[i];
            borrow[i + 1] = (~x_i[i] & y_i[i]) | (~(x_i[i] ^ y_i[i]) & borrow[i]);
        end
        bout_o = borrow[SLICE];
    end

endmodule

// File: rtl/csa_sub_8bit.sv
// ---------------------------------------------------------------------------
// csa_sub_8bit
// Two-stage pipelined carry-select subtractor: diff = (a - b - bin) mod 2^WIDTH.
// Stage 1 computes the low slice and both possible high slices in parallel;
// stage 2 picks the high slice with the low borrow and registers the result.
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   csaBus operand/result bus (slave side), see csa_sub_8bit_if
// Optional feature: define CSA_SUB_OVF_EN to add the signed-overflow flag ovf.
// ---------------------------------------------------------------------------
module csa_sub_8bit
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int SLICE = CSA_SLICE
) (
    input  logic          clk,
    input  logic          rst,
    csa_sub_8bit_if.slave csaBus
);

    logic [SLICE-1:0] lowDiff;
    logic             lowBorrow;
    logic [SLICE-1:0] highDiff0;
    logic             highBorrow0;
    logic [SLICE-1:0] highDiff1;
    logic             highBorrow1;

    logic             s1Valid_q;
    stage1Payload_t   s1Payload_q;
    stage1Payload_t   s1Payload_d;

    logic             outValid_q;
    logic             outValid_d;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             bout_q;
    logic             bout_d;
`ifdef CSA_SUB_OVF_EN
    logic             ovf_q;
    logic             ovf_d;
`endif

    logic             s2Load;
    logic             s1Load;
    logic             accept;

    // Low slice with the real borrow-in, high slice twice with both possible
    // borrows so stage 2 only has to select.
    csa_sub_slice #(.SLICE(SLICE)) uLow (
        .x_i    (csaBus.a[SLICE-1:0]),
        .y_i    (csaBus.b[SLICE-1:0]),
        .bin_i  (csaBus.bin),
        .diff_o (lowDiff),
        .bout_o (lowBorrow)
    );

    csa_sub_slice #(.SLICE(SLICE)) uHigh0 (
        .x_i    (csaBus.a[WIDTH-1:SLICE]),
        .y_i    (csaBus.b[WIDTH-1:SLICE]),
        .bin_i  (1'b0),
        .diff_o (highDiff0),
        .bout_o (highBorrow0)
    );

    csa_sub_slice #(.SLICE(SLICE)) uHigh1 (
        .x_i    (csaBus.a[WIDTH-1:SLICE]),
        .y_i    (csaBus.b[WIDTH-1:SLICE]),
        .bin_i  (1'b1),
        .diff_o (highDiff1),
        .bout_o (highBorrow1)
    );

    // Pipeline flow control without a skid buffer: stage 2 takes new data
    // when it is empty or its result leaves this cycle, and stage 1 can take
    // an operand when it is empty or its content moves into stage 2.  Reset
    // forces in_ready high because whatever is in flight is being discarded.
    always_comb begin
        s2Load          = !outValid_q || csaBus.out_ready;
        s1Load          = !s1Valid_q || s2Load;
        accept          = csaBus.in_valid && s1Load;
        csaBus.in_ready = rst || s1Load;
    end

    // Pack the stage-1 results together with the operand sign bits.
    always_comb begin
        s1Payload_d             = '0;
        s1Payload_d.lowDiff     = lowDiff;
        s1Payload_d.lowBorrow   = lowBorrow;
        s1Payload_d.highDiff0   = highDiff0;
        s1Payload_d.highDiff1   = highDiff1;
        s1Payload_d.highBorrow0 = highBorrow0;
        s1Payload_d.highBorrow1 = highBorrow1;
        s1Payload_d.aSign       = csaBus.a[WIDTH-1];
        s1Payload_d.bSign       = csaBus.b[WIDTH-1];
    end

    // Stage 1 valid flag; it only changes when stage 1 is allowed to load,
    // so a stalled operand stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
        end else if (s1Load) begin
            s1Valid_q <= accept;
        end
    end

    // Stage 1 data needs no reset: it is qualified by s1Valid_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1Payload_q <= s1Payload_d;
        end
    end

    // Stage 2 next state: the low borrow picks which speculative high slice
    // (and which high borrow) is the real one.  Output data is left alone
    // when stage 1 has nothing to hand over.
    always_comb begin
        outValid_d = outValid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
`ifdef CSA_SUB_OVF_EN
        ovf_d      = ovf_q;
`endif
        if (s2Load) begin
            outValid_d = s1Valid_q;
            if (s1Valid_q) begin
                diff_d = {(s1Payload_q.lowBorrow ? s1Payload_q.highDiff1
                                                 : s1Payload_q.highDiff0),
                          s1Payload_q.lowDiff};
                bout_d = s1Payload_q.lowBorrow ? s1Payload_q.highBorrow1
                                               : s1Payload_q.highBorrow0;
`ifdef CSA_SUB_OVF_EN
                // Signed overflow: operands of different sign and a result
                // whose sign differs from the minuend.
                ovf_d  = (s1Payload_q.aSign != s1Payload_q.bSign) &&
                         (diff_d[WIDTH-1] != s1Payload_q.aSign);
`endif
            end
        end
    end

    // Stage 2 / output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
`ifdef CSA_SUB_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            outValid_q <= outValid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
`ifdef CSA_SUB_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

`ifndef CSA_SUB_OVF_EN
    // The sign bits are only consumed by the overflow logic.
    logic unusedSigns;
    assign unusedSigns = s1Payload_q.aSign ^ s1Payload_q.bSign;
`endif

    assign csaBus.out_valid = outValid_q;
    assign csaBus.diff      = diff_q;
    assign csaBus.bout      = bout_q;
`ifdef CSA_SUB_OVF_EN
    assign csaBus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csa_sub_8bit.sv
// ---------------------------------------------------------------------------
// tb_csa_sub_8bit
// Self-checking bench for csa_sub_8bit: directed vector table with
// hand-computed results, a backpressured stream, and reset with results in
// flight.  Overflow results are checked when CSA_SUB_OVF_EN is defined.
// ---------------------------------------------------------------------------
module tb_csa_sub_8bit;
    import csa_pkg::*;

    localparam int W = CSA_WIDTH;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] expDiff;
        logic       expBout;
        logic       expOvf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    int totalChecks = 0;
    int badChecks   = 0;

    csa_sub_8bit_if #(.WIDTH(W)) itf ();

    csa_sub_8bit #(.WIDTH(W), .SLICE(CSA_SLICE)) dut (
        .clk    (clk),
        .rst    (rst),
        .csaBus (itf)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure line on mismatch.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare the registered result against expected values.
    task automatic checkOutput(input string tag, input logic [7:0] expDiff,
                               input logic expBout, input logic expOvf);
        checkVal({tag, " out_valid"}, 32'(itf.out_valid), 32'd1);
        checkVal({tag, " diff"},      32'(itf.diff),      32'(expDiff));
        checkVal({tag, " bout"},      32'(itf.bout),      32'(expBout));
`ifdef CSA_SUB_OVF_EN
        checkVal({tag, " ovf"},       32'(itf.ovf),       32'(expOvf));
`else
        if (expOvf === 1'bx) $display("[TB] unexpected x in expOvf");
`endif
    endtask

    // Present one operand set and wait for the two-cycle latency; out_valid
    // must still be low after the first edge.
    task automatic applyStimulus(input string tag, input logic [7:0] a,
                                 input logic [7:0] b, input logic bin);
        itf.a         = a;
        itf.b         = b;
        itf.bin       = bin;
        itf.in_valid  = 1'b1;
        itf.out_ready = 1'b1;
        #1;
        checkVal({tag, " in_ready"}, 32'(itf.in_ready), 32'd1);
        @(posedge clk);
        #1;
        itf.in_valid = 1'b0;
        checkVal({tag, " early out_valid"}, 32'(itf.out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    logic [7:0] sA[6];
    logic [7:0] sB[6];
    logic       sBin[6];
    logic [7:0] sDiff[6];
    logic       sBout[6];

    initial begin
        // Directed table: a, b, bin, diff, bout, ovf.
        vecs[0]  = '{8'd5,   8'd2,   1'b0, 8'd3,   1'b0, 1'b0};
        vecs[1]  = '{8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 1'b0};
        vecs[2]  = '{8'd20,  8'd20,  1'b1, 8'd255, 1'b1, 1'b0};
        vecs[3]  = '{8'd128, 8'd1,   1'b0, 8'd127, 1'b0, 1'b1};
        vecs[4]  = '{8'd200, 8'd20,  1'b0, 8'd180, 1'b0, 1'b0};
        vecs[5]  = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0};
        vecs[6]  = '{8'd16,  8'd1,   1'b0, 8'd15,  1'b0, 1'b0};
        vecs[7]  = '{8'd100, 8'd200, 1'b0, 8'd156, 1'b1, 1'b1};
        vecs[8]  = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 1'b0};
        vecs[9]  = '{8'd127, 8'd255, 1'b0, 8'd128, 1'b1, 1'b1};
        vecs[10] = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b0};
        vecs[11] = '{8'd240, 8'd15,  1'b1, 8'd224, 1'b0, 1'b0};

        // Stream operands and their hand-computed results.
        sA    = '{8'd10, 8'd3,   8'd200, 8'd0,   8'd77,  8'd128};
        sB    = '{8'd4,  8'd9,   8'd100, 8'd1,   8'd77,  8'd1};
        sBin  = '{1'b0,  1'b1,   1'b0,   1'b0,   1'b1,   1'b0};
        sDiff = '{8'd6,  8'd249, 8'd100, 8'd255, 8'd255, 8'd127};
        sBout = '{1'b0,  1'b1,   1'b0,   1'b1,   1'b1,   1'b0};

        // Reset state.
        rst           = 1'b1;
        itf.in_valid  = 1'b0;
        itf.out_ready = 1'b1;
        itf.a         = '0;
        itf.b         = '0;
        itf.bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset out_valid", 32'(itf.out_valid), 32'd0);
        checkVal("reset diff",      32'(itf.diff),      32'd0);
        checkVal("reset bout",      32'(itf.bout),      32'd0);
        checkVal("reset in_ready",  32'(itf.in_ready),  32'd1);
        rst = 1'b0;

        // Directed vectors, first one accepted on the first edge out of reset.
        for (int i = 0; i < 12; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin);
            checkOutput($sformatf("vec%0d", i), vecs[i].expDiff, vecs[i].expBout, vecs[i].expOvf);
        end

        // Drain the last result.
        @(posedge clk);
        #1;
        checkVal("drain out_valid", 32'(itf.out_valid), 32'd0);

        // Stream of 6 with out_ready low for cycles 2..4.
        begin
            int   sent = 0;
            int   got = 0;
            logic m1 = 1'b0;
            logic m2 = 1'b0;
            logic expReady;
            logic acc;
            logic prevStall = 1'b0;
            logic [7:0] prevDiff = '0;
            logic sawNotReady = 1'b0;
            for (int c = 0; c < 40 && got < 6; c++) begin
                itf.in_valid = (sent < 6);
                if (sent < 6) begin
                    itf.a   = sA[sent];
                    itf.b   = sB[sent];
                    itf.bin = sBin[sent];
                end
                itf.out_ready = !(c >= 2 && c < 5);
                #1;
                expReady = !m1 || !m2 || itf.out_ready;
                if (!expReady) sawNotReady = 1'b1;
                checkVal($sformatf("stream c%0d in_ready", c), 32'(itf.in_ready), 32'(expReady));
                checkVal($sformatf("stream c%0d out_valid", c), 32'(itf.out_valid), 32'(m2));
                if (prevStall) begin
                    checkVal($sformatf("stream c%0d held diff", c), 32'(itf.diff), 32'(prevDiff));
                end
                if (itf.out_valid && itf.out_ready) begin
                    if (got < 6) begin
                        checkVal($sformatf("stream r%0d diff", got), 32'(itf.diff), 32'(sDiff[got]));
                        checkVal($sformatf("stream r%0d bout", got), 32'(itf.bout), 32'(sBout[got]));
                    end else begin
                        checkVal("stream extra result", 32'(got), 32'd6);
                    end
                    got++;
                end
                prevStall = itf.out_valid && !itf.out_ready;
                prevDiff  = itf.diff;
                acc = itf.in_valid && expReady;
                if (acc) sent++;
                @(posedge clk);
                #1;
                if (!m2 || itf.out_ready) begin
                    m2 = m1;
                    m1 = acc;
                end else if (!m1) begin
                    m1 = acc;
                end
            end
            itf.in_valid = 1'b0;
            checkVal("stream results", 32'(got), 32'd6);
            checkVal("stream in_ready dropped", 32'(sawNotReady), 32'd1);
        end

        // Two results in flight, then a one-cycle reset.
        itf.out_ready = 1'b0;
        itf.in_valid  = 1'b1;
        itf.a = 8'd50; itf.b = 8'd8; itf.bin = 1'b0;
        @(posedge clk);
        #1;
        itf.a = 8'd9; itf.b = 8'd90; itf.bin = 1'b1;
        @(posedge clk);
        #1;
        itf.in_valid = 1'b0;
        checkVal("inflight out_valid", 32'(itf.out_valid), 32'd1);
        checkVal("inflight diff",      32'(itf.diff),      32'd42);
        checkVal("inflight in_ready",  32'(itf.in_ready),  32'd0);
        rst = 1'b1;
        #1;
        checkVal("during reset in_ready", 32'(itf.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkVal("after reset out_valid", 32'(itf.out_valid), 32'd0);
        checkVal("after reset diff",      32'(itf.diff),      32'd0);
        checkVal("after reset bout",      32'(itf.bout),      32'd0);
        checkVal("after reset in_ready",  32'(itf.in_ready),  32'd1);
        itf.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkVal($sformatf("no stale c%0d", i), 32'(itf.out_valid), 32'd0);
        end

        // Normal operation resumes after reset.
        applyStimulus("post reset", 8'd5, 8'd2, 1'b0);
        checkOutput("post reset", 8'd3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
